defuzz_centroid: RTL and testbench

- Downstream consumer of the trapezoid membership stage in the fuzzy datapath.
- Accepts a frame of (mu, z) pairs over a valid/ready stream.
  - mu: Q15 firing strength, 0..0x7FFF.
  - z: signed 8-bit singleton output position.
- Accumulates sum(mu*z) and sum(mu), then runs a sequential restoring divide to produce the crisp signed 8-bit centroid.
- Result is held on a valid/ready output until consumed.

---
 rtl/defuzz_centroid.sv | 149 ++++++++++++++
 tb/tb_defuzz_centroid.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/defuzz_centroid.sv
// Centroid defuzzifier: accumulates sum(mu*z) and sum(mu) over a frame of
// (mu, z) beats, then divides them with a sequential restoring divider to
// produce a signed crisp output, held on a valid/ready port until consumed.
module defuzz_centroid #(
  parameter int MU_W       = 16,
  parameter int Z_W        = 8,
  parameter int LOG2_TERMS = 4,
  parameter int ZERO_OUT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MU_W-1:0]       in_mu,
  input  logic signed [Z_W-1:0] in_z,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Z_W-1:0] out_crisp,
  output logic                  out_zero_w,
  output logic                  out_ovf,
  output logic                  busy
);
  localparam int NUM_W  = MU_W + Z_W + LOG2_TERMS + 1;
  localparam int DEN_W  = MU_W + LOG2_TERMS;
  localparam int CNT_W  = LOG2_TERMS + 1;
  localparam int PROD_W = MU_W + Z_W + 1;
  localparam int STEP_W = $clog2(Z_W + 1);

  typedef enum logic [1:0] {ACC, DIV, DONE} state_t;

  state_t                   state;
  logic signed [NUM_W-1:0]  num;
  logic [DEN_W-1:0]         den;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_acc;
  // divider state: magnitude remainder, shifted divisor, quotient bits
  logic [NUM_W-1:0]         rem, dvs;
  logic [Z_W-1:0]           quo;
  logic                     neg, zero, sat;
  logic [STEP_W-1:0]        step;

  logic                     take, room;
  logic signed [PROD_W-1:0] prod;
  logic signed [NUM_W-1:0]  num_nxt;
  logic [DEN_W-1:0]         den_nxt;
  logic [NUM_W-1:0]         mag_nxt;
  logic [Z_W-1:0]           crisp_fin;

  assign in_ready = (state == ACC);
  assign busy     = (state != ACC);
  assign take     = in_valid && (state == ACC);
  // cnt saturates at 2^LOG2_TERMS, so its MSB marks a full frame
  assign room     = ~cnt[CNT_W-1];
  // mu is unsigned, so zero-extend before the signed multiply
  assign prod     = $signed({1'b0, in_mu}) * in_z;

  // Next accumulator values for the beat being offered
  always_comb begin
    num_nxt = num;
    den_nxt = den;
    if (room) begin
      num_nxt = num + {{(NUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      den_nxt = den + {{LOG2_TERMS{1'b0}}, in_mu};
    end
    mag_nxt = num_nxt[NUM_W-1] ? NUM_W'(-num_nxt) : NUM_W'(num_nxt);
  end

  // Sign application and saturation of the finished quotient
  always_comb begin
    crisp_fin = quo;
    if (zero)
      crisp_fin = Z_W'(ZERO_OUT);
    else if (!neg) begin
      if (sat || quo[Z_W-1]) crisp_fin = {1'b0, {(Z_W-1){1'b1}}};
    end else if (sat || (quo[Z_W-1] && |quo[Z_W-2:0]))
      crisp_fin = {1'b1, {(Z_W-1){1'b0}}};
    else
      crisp_fin = -quo;
  end

  // Frame FSM: accumulate, divide MSB-first, then hold the result.
  // Zero-weight frames skip the divide steps but still pass through the
  // single finalize cycle, so both paths share the same output register path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACC;
      num        <= '0;
      den        <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      neg        <= 1'b0;
      zero       <= 1'b0;
      sat        <= 1'b0;
      step       <= '0;
      out_valid  <= 1'b0;
      out_crisp  <= '0;
      out_zero_w <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        ACC: if (take) begin
          num     <= num_nxt;
          den     <= den_nxt;
          cnt     <= room ? cnt + 1'b1 : cnt;
          ovf_acc <= ovf_acc | ~room;
          if (in_last) begin
            state <= DIV;
            rem   <= mag_nxt;
            dvs   <= {{(NUM_W-DEN_W-Z_W+1){1'b0}}, den_nxt, {(Z_W-1){1'b0}}};
            quo   <= '0;
            neg   <= num_nxt[NUM_W-1];
            zero  <= (den_nxt == '0);
            // quotient would need more than Z_W bits
            sat   <= mag_nxt >= {{(NUM_W-DEN_W-Z_W){1'b0}}, den_nxt, {Z_W{1'b0}}};
            step  <= (den_nxt == '0) ? STEP_W'(Z_W) : '0;
          end
        end
        DIV: if (step != STEP_W'(Z_W)) begin
          if (rem >= dvs) begin
            rem <= rem - dvs;
            quo <= {quo[Z_W-2:0], 1'b1};
          end else
            quo <= {quo[Z_W-2:0], 1'b0};
          dvs  <= dvs >> 1;
          step <= step + 1'b1;
        end else begin
          state      <= DONE;
          out_valid  <= 1'b1;
          out_crisp  <= crisp_fin;
          out_zero_w <= zero;
          out_ovf    <= ovf_acc;
        end
        DONE: if (out_ready) begin
          state     <= ACC;
          out_valid <= 1'b0;
          num       <= '0;
          den       <= '0;
          cnt       <= '0;
          ovf_acc   <= 1'b0;
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_defuzz_centroid.sv
// Bench for defuzz_centroid: directed frames plus random frames, each checked
// against a plain-arithmetic weighted-average model.
module tb_defuzz_centroid;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_mu = '0;
  logic signed [7:0] in_z = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_crisp;
  logic              out_zero_w;
  logic              out_ovf;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int fmu[$];
  int fz[$];

  defuzz_centroid dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mu(in_mu), .in_z(in_z), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_crisp(out_crisp), .out_zero_w(out_zero_w),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: weighted average of the first 16 terms, truncated toward zero
  function automatic void model(output int crisp, output int zw, output int ovf);
    longint num = 0, den = 0, q;
    for (int i = 0; i < fmu.size() && i < 16; i++) begin
      num += longint'(fmu[i]) * longint'(fz[i]);
      den += longint'(fmu[i]);
    end
    ovf = (fmu.size() > 16) ? 1 : 0;
    if (den == 0) begin
      crisp = 0;
      zw = 1;
    end else begin
      q = ((num < 0) ? -num : num) / den;
      if (num < 0) q = -q;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      crisp = int'(q);
      zw = 0;
    end
  endfunction

  task automatic send(input bit gaps);
    for (int i = 0; i < fmu.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_mu    = 16'(fmu[i]);
      in_z     = 8'(fz[i]);
      in_last  = (i == fmu.size() - 1);
      chk("in_ready_acc", int'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input int bp);
    int ec, ezw, eovf, lat, held;
    model(ec, ezw, eovf);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, ezw ? 1 : 9);
    chk({tag, "_crisp"}, int'(out_crisp), ec);
    chk({tag, "_zero_w"}, int'(out_zero_w), ezw);
    chk({tag, "_ovf"}, int'(out_ovf), eovf);
    held = int'(out_crisp);
    // offered beats during backpressure must be ignored
    for (int j = 0; j < bp; j++) begin
      in_valid = 1'b1;
      in_mu    = 16'($urandom_range(1, 32767));
      in_z     = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, "_bp_valid"}, int'(out_valid), 1);
      chk({tag, "_bp_crisp"}, int'(out_crisp), held);
      chk({tag, "_bp_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk({tag, "_drop_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  task automatic frame(input string tag, input bit gaps, input int bp);
    send(gaps);
    collect(tag, bp);
  endtask

  task automatic set2(input int m0, input int z0, input int m1, input int z1);
    fmu = '{m0, m1};
    fz  = '{z0, z1};
  endtask

  initial begin
    int ec, ezw, eovf, n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_crisp", int'(out_crisp), 0);
    chk("rst_flags", int'({out_zero_w, out_ovf}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fmu = '{32767}; fz = '{40};
    frame("single", 1'b0, 0);
    set2(24576, 60, 8192, -20);
    frame("two_pos", 1'b0, 0);
    set2(16384, -100, 16384, 100);
    frame("cancel", 1'b0, 0);
    set2(1, 1, 2, 0);
    frame("trunc_pos", 1'b0, 0);
    set2(2, -5, 1, 0);
    frame("trunc_neg", 1'b0, 0);
    set2(0, 50, 0, -50);
    frame("zero_w", 1'b0, 0);
    set2(24576, 60, 8192, -20);
    frame("bp", 1'b0, 5);
    set2(100, 7, 300, -9);
    frame("after_bp", 1'b0, 0);

    fmu.delete(); fz.delete();
    for (int i = 0; i < 17; i++) begin
      fmu.push_back(32767);
      fz.push_back(10);
    end
    frame("ovf17", 1'b0, 0);

    // reset mid-divide discards the frame
    set2(1000, -77, 3000, 55);
    send(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_stays_idle", int'(out_valid), 0);
    set2(5000, -30, 5000, 90);
    frame("post_rst", 1'b0, 0);

    for (int f = 0; f < 30; f++) begin
      fmu.delete(); fz.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if (f % 8 == 3 || $urandom_range(0, 5) == 0) fmu.push_back(0);
        else fmu.push_back($urandom_range(0, 32767));
        fz.push_back($urandom_range(0, 255) - 128);
      end
      frame("rand", 1'b1, $urandom_range(0, 3));
    end

    // extreme negative positions must reach -128 without saturating wrong
    fmu = '{32767, 32767}; fz = '{-128, -128};
    frame("min_z", 1'b0, 0);
    model(ec, ezw, eovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
